alu_sequencer: RTL and testbench

//  Control-side counterpart of the combinational ALU (zx,nx,zy,ny,f,no / x,y -> out).

---
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: Hack-style instruction sequencer that drives one external ALU.
// It accepts a 16-bit instruction word over a valid/ready handshake and runs
// each instruction through IDLE -> EXEC -> WRITE. In EXEC it drives the ALU
// controls and operands and captures the ALU result. It also keeps the A, D
// and PC registers and issues memory writes.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake; in_instr is the word
//   m_in                     memory operand M
//   zx,nx,zy,ny,f,no         ALU control bits (non-zero only in EXEC)
//   alu_x, alu_y, alu_r      ALU operands out, combinational ALU result in
//   a_reg, d_reg, pc         architectural registers
//   m_out, m_we              memory write data and 1-cycle write strobe
//   zr, ng                   flags of the last captured result
//   done                     1-cycle retire pulse (during WRITE)
module alu_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [WIDTH-1:0] m_in,
  output logic             zx,
  output logic             nx,
  output logic             zy,
  output logic             ny,
  output logic             f,
  output logic             no,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_r,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] d_reg,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] m_out,
  output logic             m_we,
  output logic             zr,
  output logic             ng,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [WIDTH-1:0]   a_q, a_d, d_q, d_d, pc_q, pc_d, m_out_q, m_out_d;
  logic               zr_q, zr_d, ng_q, ng_d, m_we_q, m_we_d, done_q, done_d;

  // Instruction register field decode
  logic               is_c;
  logic               sel_m;
  logic [5:0]         ctl;
  logic [2:0]         dest;
  logic [2:0]         jmp;
  logic               unused_ir_c;

  assign is_c        = ir_q[15];
  assign sel_m       = ir_q[12];
  assign ctl         = ir_q[11:6];
  assign dest        = ir_q[5:3];
  assign jmp         = ir_q[2:0];
  assign unused_ir_c = ^ir_q[14:13];

  // Flags of the result being captured this cycle and the jump decision
  logic               r_zr, r_ng, taken;
  logic               exec_c;

  assign r_zr   = (alu_r == '0);
  assign r_ng   = alu_r[WIDTH-1];
  assign taken  = (jmp[2] & r_ng) | (jmp[1] & r_zr) | (jmp[0] & ~r_ng & ~r_zr);
  assign exec_c = (state_q == EXEC) && is_c;

  // ALU drive: only a C-instruction in EXEC produces non-zero controls/operands
  assign {zx, nx, zy, ny, f, no} = exec_c ? ctl : 6'd0;
  assign alu_x    = exec_c ? d_q : '0;
  assign alu_y    = exec_c ? (sel_m ? m_in : a_q) : '0;
  assign in_ready = (state_q == IDLE);

  assign a_reg = a_q;
  assign d_reg = d_q;
  assign pc    = pc_q;
  assign m_out = m_out_q;
  assign m_we  = m_we_q;
  assign zr    = zr_q;
  assign ng    = ng_q;
  assign done  = done_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      m_out_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      m_we_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      m_out_q <= m_out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      m_we_q  <= m_we_d;
      done_q  <= done_d;
    end
  end

  // Next-state and capture logic; done/m_we are set leaving EXEC so they are high in WRITE
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    m_out_d = m_out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    m_we_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ir_d    = in_instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WRITE;
        done_d  = 1'b1;
        if (is_c) begin
          if (dest[2]) a_d = alu_r;
          if (dest[1]) d_d = alu_r;
          if (dest[0]) begin
            m_out_d = alu_r;
            m_we_d  = 1'b1;
          end
          zr_d = r_zr;
          ng_d = r_ng;
          // a_q still holds the pre-instruction A value here
          pc_d = taken ? a_q : pc_q + WIDTH'(1);
        end else begin
          a_d  = ir_q[WIDTH-1:0];
          pc_d = pc_q + WIDTH'(1);
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_instr = 16'h0000;
  logic [W-1:0] m_in = 4'h9;
  logic         zx, nx, zy, ny, f, no;
  logic [W-1:0] alu_x, alu_y, alu_r;
  logic [W-1:0] a_reg, d_reg, pc, m_out;
  logic         m_we, zr, ng, done;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .m_in(m_in),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_x(alu_x), .alu_y(alu_y), .alu_r(alu_r),
    .a_reg(a_reg), .d_reg(d_reg), .pc(pc), .m_out(m_out), .m_we(m_we),
    .zr(zr), .ng(ng), .done(done)
  );

  always #5 clk = ~clk;

  // Reference Hack ALU
  logic [W-1:0] x1, x2, y1, y2, o1;
  always_comb begin
    x1 = zx ? '0 : alu_x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : alu_y;
    y2 = ny ? ~y1 : y1;
    o1 = f ? (x2 + y2) : (x2 & y2);
    alu_r = no ? ~o1 : o1;
  end

  typedef struct {
    logic [5:0]   ctl;
    logic [W-1:0] ax, ay, a, d, p, mo;
    logic         zr, ng, mwe;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic exp_t mk(input logic [5:0] c, input logic [W-1:0] ax, ay, a, d, p, mo,
                              input logic ez, en, ew);
    exp_t e;
    e.ctl = c; e.ax = ax; e.ay = ay; e.a = a; e.d = d; e.p = p; e.mo = mo;
    e.zr = ez; e.ng = en; e.mwe = ew;
    return e;
  endfunction

  // Monitor: handshake seen at posedge, EXEC checked next negedge, retire one after
  logic acc_pend = 1'b0;
  logic exec_prev = 1'b0;

  always @(posedge clk) acc_pend <= rst_n && in_valid && in_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      exec_prev = 1'b0;
    end else begin
      if (acc_pend) begin
        if (exp_q.size() == 0) fail_now("exec_no_expectation");
        else begin
          cur = exp_q[0];
          chk("exec_ctl", 32'({zx, nx, zy, ny, f, no}), 32'(cur.ctl));
          chk("exec_alu_x", 32'(alu_x), 32'(cur.ax));
          chk("exec_alu_y", 32'(alu_y), 32'(cur.ay));
        end
      end else begin
        chk("idle_ctl", 32'({zx, nx, zy, ny, f, no}), 32'd0);
        chk("idle_alu_xy", 32'({alu_x, alu_y}), 32'd0);
      end
      if (exec_prev) begin
        chk("done_pulse", 32'(done), 32'd1);
        if (exp_q.size() == 0) fail_now("retire_no_expectation");
        else begin
          cur = exp_q.pop_front();
          chk("a_reg", 32'(a_reg), 32'(cur.a));
          chk("d_reg", 32'(d_reg), 32'(cur.d));
          chk("pc", 32'(pc), 32'(cur.p));
          chk("zr", 32'(zr), 32'(cur.zr));
          chk("ng", 32'(ng), 32'(cur.ng));
          chk("m_we", 32'(m_we), 32'(cur.mwe));
          if (cur.mwe) chk("m_out", 32'(m_out), 32'(cur.mo));
        end
      end else begin
        chk("done_idle", 32'(done), 32'd0);
        chk("m_we_idle", 32'(m_we), 32'd0);
      end
      exec_prev = acc_pend;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
  endtask

  // Single instruction with in_valid dropped after acceptance; called at a negedge
  task automatic issue(input logic [15:0] ins, input exp_t e);
    wait_ready();
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 16'hFFFF;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_regs"}, 32'({a_reg, d_reg, pc}), 32'd0);
    chk({nm, "_strobes"}, 32'({m_we, done}), 32'd0);
    chk({nm, "_flags_mout"}, 32'({zr, ng, m_out}), 32'd0);
  endtask

  logic [15:0] stream_ins [3];
  exp_t        stream_exp [3];

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("rst_idle");

    issue(16'h0005, mk(6'b000000, 4'h0, 4'h0, 4'h5, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0));
    issue(16'hEC10, mk(6'b110000, 4'h0, 4'h5, 4'h5, 4'h5, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0));
    issue(16'hE090, mk(6'b000010, 4'h5, 4'h5, 4'h5, 4'hA, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0));
    issue(16'hE304, mk(6'b001100, 4'hA, 4'h5, 4'h5, 4'hA, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0));
    issue(16'hE308, mk(6'b001100, 4'hA, 4'h5, 4'h5, 4'hA, 4'h6, 4'hA, 1'b0, 1'b1, 1'b1));
    issue(16'hFC10, mk(6'b110000, 4'hA, 4'h9, 4'h5, 4'h9, 4'h7, 4'hA, 1'b0, 1'b1, 1'b0));
    issue(16'h0002, mk(6'b000000, 4'h0, 4'h0, 4'h2, 4'h9, 4'h8, 4'hA, 1'b0, 1'b1, 1'b0));
    issue(16'hEA87, mk(6'b101010, 4'h9, 4'h2, 4'h2, 4'h9, 4'h2, 4'hA, 1'b1, 1'b0, 1'b0));
    issue(16'hEA81, mk(6'b101010, 4'h9, 4'h2, 4'h2, 4'h9, 4'h3, 4'hA, 1'b1, 1'b0, 1'b0));

    // in_valid held high across several instructions; includes jump to 15 and pc wrap
    stream_ins[0] = 16'h000F;
    stream_exp[0] = mk(6'b000000, 4'h0, 4'h0, 4'hF, 4'h9, 4'h4, 4'hA, 1'b1, 1'b0, 1'b0);
    stream_ins[1] = 16'hEA87;
    stream_exp[1] = mk(6'b101010, 4'h9, 4'hF, 4'hF, 4'h9, 4'hF, 4'hA, 1'b1, 1'b0, 1'b0);
    stream_ins[2] = 16'h0001;
    stream_exp[2] = mk(6'b000000, 4'h0, 4'h0, 4'h1, 4'h9, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0);
    wait_ready();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = stream_ins[i];
      exp_q.push_back(stream_exp[i]);
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Reset during EXEC of D=D+A: no update, no done
    wait_ready();
    exp_q.push_back(mk(6'b000010, 4'h9, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b1;
    in_instr = 16'hE090;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state("abort");
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0003, mk(6'b000000, 4'h0, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0));
    issue(16'hE090, mk(6'b000010, 4'h0, 4'h3, 4'h3, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0));
    // A=0;JMP: jump target is the A value from before the instruction
    issue(16'hEAA7, mk(6'b101010, 4'h3, 4'h3, 4'h0, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0));

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
